// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        FLAGS,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned FRAME_BITS = DEF_DATA_W + 6;

    localparam int unsigned FLG_CERO  = 0;
    localparam int unsigned FLG_CARRY = 1;
    localparam int unsigned FLG_OVF   = 2;

endpackage

// File: rtl/baud_tick.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while the frame is active and strobes at each bit end.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_run,
    input  logic i_clr,
    output logic o_bit_end,
    output logic o_stop_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_end  = i_run && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // The stop bit leaves one cycle early: the done/IDLE cycle supplies its final tx=1 cycle.
    assign o_stop_end = i_run && (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_ena) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= o_bit_end ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_result_tx.sv
// Serial transmitter for ALU results: START, data LSB first, 3 flags, even parity, STOP.
module alu_result_tx
    import alu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] result,
    input  logic [2:0]        flags,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_MAX = (DATA_W > FLAG_W) ? DATA_W : FLAG_W;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX);

    tx_state_t          r_state;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_sh;
    logic [FLAG_W-1:0]  r_fl;
    logic               r_par;
    logic [IDX_W-1:0]   r_idx;

    logic w_accept;
    logic w_clr;
    logic w_bit_end;
    logic w_stop_end;

    assign w_accept = ena && start && (r_state == IDLE);
    assign w_clr    = w_accept || (ena && (r_state == STOP) && w_stop_end);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ena      (ena),
        .i_run      (r_busy),
        .i_clr      (w_clr),
        .o_bit_end  (w_bit_end),
        .o_stop_end (w_stop_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sh    <= '0;
            r_fl    <= '0;
            r_par   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (ena) begin
                case (r_state)
                    IDLE: begin
                        r_tx <= 1'b1;
                        if (start) begin
                            r_sh    <= result;
                            r_fl    <= flags;
                            r_par   <= ^{result, flags};
                            r_idx   <= '0;
                            r_tx    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= START;
                        end
                    end
                    START: begin
                        if (w_bit_end) begin
                            r_tx    <= r_sh[0];
                            r_state <= DATA;
                        end
                    end
                    // tx is registered, so the next bit is taken one position ahead of the shift.
                    DATA: begin
                        if (w_bit_end) begin
                            if (r_idx == IDX_W'(DATA_W - 1)) begin
                                r_idx   <= '0;
                                r_tx    <= r_fl[FLG_CERO];
                                r_state <= FLAGS;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                                r_sh  <= r_sh >> 1;
                                r_tx  <= r_sh[1];
                            end
                        end
                    end
                    FLAGS: begin
                        if (w_bit_end) begin
                            if (r_idx == IDX_W'(FLAG_W - 1)) begin
                                r_idx   <= '0;
                                r_tx    <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                                r_fl  <= r_fl >> 1;
                                r_tx  <= r_fl[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (w_bit_end) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end
                    end
                    STOP: begin
                        if (w_stop_end) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Randomized self-checking bench: a waveform-queue reference model predicts tx/busy/done per cycle.
module tb_alu_result_tx;

    localparam int unsigned CPB = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned NB  = DW + 6;
    localparam int unsigned FRAME_CYC = NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] result = '0;
    logic [2:0]    flags = '0;
    logic          tx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    alu_result_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .result (result),
        .flags  (flags),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          chk_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: on accept, the whole frame is expanded into one tx value per enabled cycle.
    // The last stop-bit cycle is the idle/done cycle, during which a new start may be accepted.
    bit mq[$];
    bit m_done;

    function automatic void load_frame(input logic [DW-1:0] r, input logic [2:0] f);
        bit b[NB];
        b[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) b[1 + i] = r[i];
        for (int i = 0; i < 3; i++) b[1 + DW + i] = f[i];
        b[NB-2] = bit'($countones({r, f}) % 2);
        b[NB-1] = 1'b1;
        mq.delete();
        for (int i = 0; i < int'(NB); i++)
            for (int j = 0; j < int'(CPB); j++) mq.push_back(b[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            bit idle_now;
            m_done = 1'b0;
            if (ena) begin
                idle_now = (mq.size() <= 1);
                if (mq.size() > 0) begin
                    void'(mq.pop_front());
                    if (mq.size() == 1) m_done = 1'b1;
                end
                if (idle_now && start) load_frame(result, flags);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx",   {31'd0, tx},   {31'd0, (mq.size() > 0) ? mq[0] : 1'b1});
            chk("busy", {31'd0, busy}, {31'd0, mq.size() > 1});
            chk("done", {31'd0, done}, {31'd0, m_done});
        end
    end

    bit exp2[NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1};

    task automatic start_frame(input logic [DW-1:0] r, input logic [2:0] f);
        @(negedge clk);
        result = r;
        flags  = f;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        int unsigned k;
        int unsigned k1;
        int unsigned k2;
        int unsigned ndone;
        int unsigned tr;
        logic        prev;
        bit          got;

        // Test 1: reset and quiet idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        ena    = 1'b1;
        chk_on = 1'b1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tr = 0;
        prev = tx;
        repeat (50) begin
            @(negedge clk);
            if (tx !== prev) tr++;
            prev = tx;
        end
        chk("idle_toggles", tr, 0);

        // Test 2: single frame 0xA5 / 3'b010
        start_frame(8'hA5, 3'b010);
        k = 1;
        got = 1'b0;
        while (k < 400 && !got) begin
            if ((k % CPB) == 8 && (k / CPB) < NB) chk("t2_bit", {31'd0, tx}, {31'd0, exp2[k / CPB]});
            if (k == (NB - 2) * CPB + 8) chk("t2_parity", {31'd0, tx}, 32'd1);
            if (done === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("t2_done_lat", k, FRAME_CYC);
        repeat (20) @(negedge clk);

        // Test 3: start and input change while busy are ignored
        start_frame(8'h3C, 3'b101);
        repeat (5 * CPB - 1) @(negedge clk);
        result = 8'hFF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        result = 8'h00;
        ndone = 0;
        repeat (400) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("t3_done_cnt", ndone, 1);

        // Test 4: back-to-back frames with start held high
        @(negedge clk);
        result = 8'h00;
        flags  = 3'b000;
        start  = 1'b1;
        k = 0;
        k1 = 0;
        k2 = 0;
        ndone = 0;
        while (k < 700 && ndone < 2) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) k1 = k;
                else begin
                    k2 = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("t4_done_cnt", ndone, 2);
        chk("t4_gap", k2 - k1, FRAME_CYC);
        repeat (30) @(negedge clk);

        // Test 5: enable freeze during D3
        start_frame(8'h5A, 3'b001);
        repeat (4 * CPB + 7) @(negedge clk);
        ena = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("t5_hold", {31'd0, tx}, 32'd1);
        end
        ena = 1'b1;
        repeat (260) @(negedge clk);

        // Test 6: asynchronous reset during FLAGS, then a clean frame
        start_frame(8'h96, 3'b110);
        repeat (10 * CPB + 4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_tx", {31'd0, tx}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start_frame(8'hC3, 3'b011);
        repeat (FRAME_CYC + 20) @(negedge clk);

        // Random phase
        repeat (3000) begin
            @(negedge clk);
            start  = ($urandom_range(7) == 0);
            ena    = ($urandom_range(15) != 0);
            result = DW'($urandom);
            flags  = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        repeat (FRAME_CYC + 10) @(negedge clk);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
